// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - short/long/double press decoder; BTN_EVENT_REPEAT_EN adds auto-repeat while held
module button_event_decoder #(
    parameter int LONG_CYCLES       = 50000000,
    parameter int DOUBLE_GAP_CYCLES = 15000000,
    parameter int REPEAT_CYCLES     = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic held,
    output logic repeat_press
);

    localparam int MAX_LG  = (LONG_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int MAX_CYC = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYC - 1);
`ifdef BTN_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_LONG_HELD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_btn_q;
    logic             w_short_nxt;
    logic             w_long_nxt;
    logic             w_double_nxt;
    logic             w_held_nxt;

    // saturating increment keeps the shared counter from ever wrapping
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // r_btn_q resets high so a button held through reset needs a fresh rise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_btn_q      <= 1'b1;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            held         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_btn_q      <= btn_level;
            short_press  <= w_short_nxt;
            long_press   <= w_long_nxt;
            double_press <= w_double_nxt;
            held         <= w_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (btn_level && !r_btn_q) w_state_nxt = S_PRESS1;
            end
            S_PRESS1: begin
                if (!btn_level) begin
                    w_state_nxt = S_WAIT2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LONG_TC) begin
                    w_state_nxt = S_LONG_HELD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAIT2: begin
                if (btn_level) begin
                    w_state_nxt = S_PRESS2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == GAP_TC) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_PRESS2: begin
                w_cnt_nxt = '0;
                if (!btn_level) w_state_nxt = S_IDLE;
            end
            S_LONG_HELD: begin
                if (!btn_level) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
`ifdef BTN_EVENT_REPEAT_EN
                    w_cnt_nxt = (r_cnt == REP_TC) ? '0 : w_cnt_inc;
`else
                    w_cnt_nxt = '0;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_short_nxt  = (r_state == S_WAIT2) && !btn_level && (r_cnt == GAP_TC);
        w_long_nxt   = (r_state == S_PRESS1) && btn_level && (r_cnt == LONG_TC);
        w_double_nxt = (r_state == S_WAIT2) && btn_level;
        w_held_nxt   = (w_state_nxt == S_LONG_HELD);
    end

`ifdef BTN_EVENT_REPEAT_EN
    logic w_repeat_nxt;

    assign w_repeat_nxt = (r_state == S_LONG_HELD) && btn_level && (r_cnt == REP_TC);

    always_ff @(posedge clk) begin
        if (!rst_n) repeat_press <= 1'b0;
        else        repeat_press <= w_repeat_nxt;
    end
`else
    assign repeat_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder
module tb_button_event_decoder;

    localparam int LC = 20;
    localparam int GC = 8;
    localparam int RC = 5;

    localparam int K_SHORT    = 0;
    localparam int K_LONG     = 1;
    localparam int K_DOUBLE   = 2;
    localparam int K_REPEAT   = 3;
    localparam int K_HELD_ON  = 4;
    localparam int K_HELD_OFF = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_level = 1'b1;
    logic short_press, long_press, double_press, held, repeat_press;

    button_event_decoder #(
        .LONG_CYCLES(LC),
        .DOUBLE_GAP_CYCLES(GC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_level(btn_level),
        .short_press(short_press),
        .long_press(long_press),
        .double_press(double_press),
        .held(held),
        .repeat_press(repeat_press)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int   exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_held = 1'b0;
    logic mon_en = 1'b0;

    function automatic string kname(input int k);
        case (k)
            K_SHORT:    return "short";
            K_LONG:     return "long";
            K_DOUBLE:   return "double";
            K_REPEAT:   return "repeat";
            K_HELD_ON:  return "held_on";
            default:    return "held_off";
        endcase
    endfunction

    task automatic expect_ev(input int c, input int k);
        exp_q.push_back(c * 8 + k);
    endtask

    task automatic observe(input int k);
        int want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_%s: seen at cycle %0d, required no event", kname(k), cyc);
        end else begin
            want = exp_q.pop_front();
            if (want != cyc * 8 + k) begin
                errors++;
                $display("FAIL event_%s: seen at cycle %0d, required %s at cycle %0d",
                         kname(k), cyc, kname(want % 8), want / 8);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (int'(short_press) + int'(long_press) + int'(double_press) > 1) begin
                errors++;
                $display("FAIL exclusive: cycle %0d got s/l/d=%b%b%b, required at most one",
                         cyc, short_press, long_press, double_press);
            end
            if (short_press)        observe(K_SHORT);
            if (long_press)         observe(K_LONG);
            if (double_press)       observe(K_DOUBLE);
            if (repeat_press)       observe(K_REPEAT);
            if (held && !prev_held) observe(K_HELD_ON);
            if (!held && prev_held) observe(K_HELD_OFF);
            prev_held = held;
        end
    end

    task automatic wait_to(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // value is applied so that edge e is the first to sample it
    task automatic drive_at(input int e, input logic v);
        wait_to(e - 1);
        btn_level = v;
    endtask

    task automatic rst_at(input int e, input logic v);
        wait_to(e - 1);
        rst_n = v;
    endtask

    int r;

    initial begin
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({short_press, long_press, double_press, held, repeat_press} != 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {short_press, long_press, double_press, held, repeat_press});
        end
        rst_at(4, 1'b1);
        mon_en = 1'b1;

        // level high through reset, then held: no events at all
        drive_at(cyc + 30, 1'b0);
        wait_to(cyc + 6);

        // short press
        r = cyc + 3;
        drive_at(r, 1'b1);
        expect_ev(r + 5 + GC, K_SHORT);
        drive_at(r + 5, 1'b0);
        wait_to(r + 5 + GC + 6);

        // long press, 40 cycles
        r = cyc + 3;
        drive_at(r, 1'b1);
        expect_ev(r + LC, K_LONG);
        expect_ev(r + LC, K_HELD_ON);
`ifdef BTN_EVENT_REPEAT_EN
        expect_ev(r + LC + RC, K_REPEAT);
        expect_ev(r + LC + 2 * RC, K_REPEAT);
        expect_ev(r + LC + 3 * RC, K_REPEAT);
`endif
        expect_ev(r + 40, K_HELD_OFF);
        drive_at(r + 40, 1'b0);
        wait_to(r + 46);

        // double press, second press held 30 cycles
        r = cyc + 3;
        drive_at(r, 1'b1);
        drive_at(r + 3, 1'b0);
        expect_ev(r + 7, K_DOUBLE);
        drive_at(r + 7, 1'b1);
        drive_at(r + 37, 1'b0);
        wait_to(r + 37 + 12);

        // release on the edge where cnt = LC-1: no long, short after gap
        r = cyc + 3;
        drive_at(r, 1'b1);
        expect_ev(r + LC + GC, K_SHORT);
        drive_at(r + LC, 1'b0);
        wait_to(r + LC + GC + 6);

        // re-press on the edge where gap cnt = GC-1: double, not short
        r = cyc + 3;
        drive_at(r, 1'b1);
        drive_at(r + 4, 1'b0);
        expect_ev(r + 4 + GC, K_DOUBLE);
        drive_at(r + 4 + GC, 1'b1);
        drive_at(r + 4 + GC + 3, 1'b0);
        wait_to(r + 4 + GC + 16);

        // reset during the release gap abandons the gesture
        r = cyc + 3;
        drive_at(r, 1'b1);
        drive_at(r + 3, 1'b0);
        rst_at(r + 6, 1'b0);
        rst_at(r + 8, 1'b1);
        wait_to(r + 25);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending, required 0 (next %s at cycle %0d)",
                     exp_q.size(), kname(exp_q[0] % 8), exp_q[0] / 8);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
